lab3_mem_test_mem_ctrl: RTL and testbench
=========================================

# lab3_mem_test_mem_ctrl

Control unit for the memory-side responder of the cache-to-memory val/rdy interface. Accepts one memory request at a time, drives the datapath enables that latch the request and access the backing array, holds a programmable response latency, then presents the response. Sits at the far end of the memreq/memresp link, opposite the cache controllers, and pairs with a separate responder datapath.

## Interface

Parameters:
- latency, 2, extra wait cycles between array access and response valid; legal range 0–15
- lat_bw, 4, counter width; local, not set from outside

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- memreq_val  in  1  request valid from the cache side
- memreq_rdy  out  1  responder can accept a request
- memreq_type  in  3  type field of the latched request, from the datapath: 3'd0 read, 3'd1 write, others treated as read
- memresp_val  out  1  response valid toward the cache side
- memresp_rdy  in  1  cache side accepts the response
- req_reg_en  out  1  datapath latches the request message this cycle
- array_wen  out  1  datapath writes the array this cycle
- resp_reg_en  out  1  datapath latches the response message this cycle

## Operation

- States are IDLE, ACCESS, WAIT and RESP. Reset state is IDLE.
- IDLE:
  - memreq_rdy=1.
  - On memreq_val, req_reg_en=1 and the next state is ACCESS.
- ACCESS:
  - resp_reg_en=1.
  - array_wen=1 only if memreq_type==3'd1.
  - If latency==0, the next state is RESP. Otherwise the counter loads latency-1 and the next state is WAIT.
- WAIT:
  - All outputs are 0.
  - If the counter is 0, the next state is RESP. Otherwise the counter decrements.
  - WAIT lasts exactly latency cycles.
- RESP:
  - memresp_val=1 and memreq_rdy=memresp_rdy.
  - memresp_rdy=0: stay in RESP and hold val; the response is never dropped.
  - memresp_rdy=1 and memreq_val=0: go to IDLE.
  - memresp_rdy=1 and memreq_val=1: both handshakes happen in the same cycle. req_reg_en=1 and the next state is ACCESS, with no bubble through IDLE.
- Outputs are decoded combinationally from the state plus the listed inputs.
- All outputs are 0 while reset is asserted, except memreq_rdy. memreq_rdy=1 whenever the state is IDLE, including during reset.
- Counter arithmetic is unsigned lat_bw bits. The counter never underflows, because it is only decremented when it is nonzero.
- Reset mid-operation, in any state, returns to IDLE at once. Any in-flight request is abandoned and no response is issued for it.
- memreq_val is sampled only in IDLE and RESP. A request held high in ACCESS or WAIT is left pending, because memreq_rdy=0 in those states.

## Timing

- A request handshake in cycle 0 gives ACCESS in cycle 1, WAIT in cycles 2 to latency+1, and memresp_val first high in cycle latency+2.
- Peak throughput is one transaction per latency+2 cycles, achieved with back-to-back handshakes in RESP.
- At most one transaction is outstanding; there is no internal buffering beyond the datapath registers.
- array_wen is a single-cycle pulse per write.
- resp_reg_en is a single-cycle pulse per transaction.

## Structure

- Shared package lab3_mem_pkg holds:
  - the request type constants MEM_TYPE_READ=3'd0 and MEM_TYPE_WRITE=3'd1;
  - the state enum {IDLE, ACCESS, WAIT, RESP}, encoded in 2 bits.
- One natural sub-module: lab3_mem_latency_counter, a lat_bw-bit down-counter.
  - Inputs: load, load_value, dec.
  - Output: is_zero.
  - Async active-low reset to 0.
- The FSM and the output decode live in the top module.

## Test plan

- latency=2, single read; memreq_val pulse in cycle 0, memresp_rdy held 1:
  - req_reg_en in cycle 0, resp_reg_en in cycle 1, array_wen never;
  - memresp_val high only in cycle 4.
- latency=0, single write:
  - array_wen=1 and resp_reg_en=1 in cycle 1;
  - memresp_val in cycle 2.
- Backpressure: latency=1, memresp_rdy=0 for 5 cycles after memresp_val rises (cycle 3):
  - memresp_val stays 1 through cycle 8 and memreq_rdy stays 0;
  - the response is accepted in cycle 8 and the state is IDLE in cycle 9.
- Back-to-back: latency=1, memreq_val and memresp_rdy held 1:
  - a request is accepted every 3 cycles (cycles 0, 3, 6);
  - req_reg_en is coincident with memresp_val in cycles 3 and 6.
- Reset mid-WAIT: latency=5, assert reset in cycle 3:
  - all outputs except memreq_rdy drop immediately;
  - after release, memreq_rdy=1 and no memresp_val appears.
- Unsupported type 3'd2 with latency=2: treated as a read, so array_wen is never asserted and memresp_val appears in cycle 4.

Source files
------------

// File: rtl/lab3_mem_pkg.sv
// Shared definitions for the memory-side responder: request type codes and the
// control FSM state encoding.
package lab3_mem_pkg;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } mem_state_e;

endpackage

// File: rtl/lab3_mem_latency_counter.sv
// Down-counter that times the response-latency WAIT phase of the responder.
module lab3_mem_latency_counter #(
  parameter int unsigned lat_bw = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [lat_bw-1:0] load_value,
  input  logic              dec,
  output logic              is_zero
);

  logic [lat_bw-1:0] count_q, count_d;

  assign is_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && !is_zero) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lab3_mem_test_mem_ctrl.sv
// Control unit for the memory-side val/rdy responder: accept, access the array,
// wait a fixed latency, then hold the response until the cache side takes it.
module lab3_mem_test_mem_ctrl
  import lab3_mem_pkg::*;
#(
  parameter int unsigned latency = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       memreq_val,
  output logic       memreq_rdy,
  input  logic [2:0] memreq_type,
  output logic       memresp_val,
  input  logic       memresp_rdy,
  output logic       req_reg_en,
  output logic       array_wen,
  output logic       resp_reg_en
);

  localparam int unsigned lat_bw = 4;
  localparam bit ZeroLat = (latency == 0);
  localparam int unsigned LatLoad = ZeroLat ? 0 : latency - 1;

  mem_state_e state_q, state_d;
  logic       cnt_load, cnt_dec, cnt_zero;

  lab3_mem_latency_counter #(
    .lat_bw(lat_bw)
  ) u_lat_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_value(lat_bw'(LatLoad)),
    .dec       (cnt_dec),
    .is_zero   (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    req_reg_en  = 1'b0;
    array_wen   = 1'b0;
    resp_reg_en = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        memreq_rdy = 1'b1;
        if (memreq_val) begin
          req_reg_en = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        resp_reg_en = 1'b1;
        array_wen   = (memreq_type == MEM_TYPE_WRITE);
        if (ZeroLat) begin
          state_d = RESP;
        end else begin
          cnt_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        memresp_val = 1'b1;
        memreq_rdy  = memresp_rdy;
        // Response and next request can both handshake here, skipping IDLE.
        if (memresp_rdy) begin
          if (memreq_val) begin
            req_reg_en = 1'b1;
            state_d    = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // State is already IDLE under reset; only the request enable needs masking.
    if (!reset) begin
      memreq_rdy  = 1'b1;
      memresp_val = 1'b0;
      req_reg_en  = 1'b0;
      array_wen   = 1'b0;
      resp_reg_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_lab3_mem_test_mem_ctrl.sv
// Bench for the memory responder control: four latency variants share stimulus and
// are checked every cycle against a transaction-age model, plus directed sequences.
module tb_lab3_mem_test_mem_ctrl;

  localparam int NDut = 4;

  logic            clk;
  logic            reset;
  logic            memreq_val;
  logic            memresp_rdy;
  logic [2:0]      memreq_type;
  logic [NDut-1:0] o_rdy, o_val, o_rqe, o_wen, o_rse;

  int lat_of [NDut] = '{0, 1, 2, 5};
  // Cycles since the request handshake; 0 means no transaction held.
  int age [NDut];

  int n_assert;
  int n_fail;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 2 : 5;
    lab3_mem_test_mem_ctrl #(
      .latency(Lat)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .memreq_val (memreq_val),
      .memreq_rdy (o_rdy[g]),
      .memreq_type(memreq_type),
      .memresp_val(o_val[g]),
      .memresp_rdy(memresp_rdy),
      .req_reg_en (o_rqe[g]),
      .array_wen  (o_wen[g]),
      .resp_reg_en(o_rse[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int i, input logic got, input logic exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d t=%0t got %b expected %b", name, lat_of[i], $time, got, exp);
    end
  endtask

  function automatic void model_out(input int i, output logic e_rdy, output logic e_val,
                                    output logic e_rqe, output logic e_wen,
                                    output logic e_rse);
    logic resp;
    logic acc;
    resp  = reset && (age[i] >= lat_of[i] + 2);
    acc   = reset && (age[i] == 1);
    e_val = resp;
    e_rdy = !reset || age[i] == 0 || (resp && memresp_rdy);
    e_rqe = reset && e_rdy && memreq_val;
    e_rse = acc;
    e_wen = acc && (memreq_type == 3'd1);
  endfunction

  task automatic model_check();
    logic e_rdy, e_val, e_rqe, e_wen, e_rse;
    for (int i = 0; i < NDut; i++) begin
      model_out(i, e_rdy, e_val, e_rqe, e_wen, e_rse);
      chk("model_memreq_rdy", i, o_rdy[i], e_rdy);
      chk("model_memresp_val", i, o_val[i], e_val);
      chk("model_req_reg_en", i, o_rqe[i], e_rqe);
      chk("model_array_wen", i, o_wen[i], e_wen);
      chk("model_resp_reg_en", i, o_rse[i], e_rse);
    end
  endtask

  task automatic model_advance();
    logic e_rdy, e_val, e_rqe, e_wen, e_rse;
    for (int i = 0; i < NDut; i++) begin
      model_out(i, e_rdy, e_val, e_rqe, e_wen, e_rse);
      if (!reset) age[i] = 0;
      else if (e_rdy && memreq_val) age[i] = 1;
      else if (e_val && memresp_rdy) age[i] = 0;
      else if (age[i] != 0 && age[i] < lat_of[i] + 2) age[i] = age[i] + 1;
    end
  endtask

  // Apply inputs (just after a rising edge), then sample at the falling edge.
  task automatic settle(input logic rst, input logic val, input logic rdy,
                        input logic [2:0] typ);
    reset       = rst;
    memreq_val  = val;
    memresp_rdy = rdy;
    memreq_type = typ;
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    settle(1'b0, 1'b0, 1'b1, 3'd0);
    tick();
  endtask

  typedef struct {
    logic       val;
    logic       rdy;
    logic [2:0] typ;
    logic       e_rdy;
    logic       e_val;
    logic       e_rqe;
    logic       e_wen;
    logic       e_rse;
  } vec_t;

  vec_t tbl [6];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < NDut; i++) age[i] = 0;

    // latency=2 single read, cycle by cycle.
    tbl[0] = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    #1;
    // Reset state, including a request held high while reset is asserted.
    settle(1'b0, 1'b1, 1'b1, 3'd1);
    for (int i = 0; i < NDut; i++) begin
      chk("reset_rdy", i, o_rdy[i], 1'b1);
      chk("reset_rqe", i, o_rqe[i], 1'b0);
      chk("reset_val", i, o_val[i], 1'b0);
    end
    tick();

    for (int c = 0; c < 6; c++) begin
      settle(1'b1, tbl[c].val, tbl[c].rdy, tbl[c].typ);
      chk("tbl_memreq_rdy", 2, o_rdy[2], tbl[c].e_rdy);
      chk("tbl_memresp_val", 2, o_val[2], tbl[c].e_val);
      chk("tbl_req_reg_en", 2, o_rqe[2], tbl[c].e_rqe);
      chk("tbl_array_wen", 2, o_wen[2], tbl[c].e_wen);
      chk("tbl_resp_reg_en", 2, o_rse[2], tbl[c].e_rse);
      tick();
    end

    // latency=0 write: access in cycle 1, response in cycle 2.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      settle(1'b1, c == 0, 1'b1, 3'd1);
      chk("lat0_wen", 0, o_wen[0], c == 1);
      chk("lat0_rse", 0, o_rse[0], c == 1);
      chk("lat0_val", 0, o_val[0], c == 2);
      tick();
    end

    // Backpressure on latency=1: response held from cycle 3 until accepted in cycle 8.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      settle(1'b1, c == 0, c >= 8, 3'd0);
      if (c >= 3 && c <= 8) chk("bp_val_held", 1, o_val[1], 1'b1);
      if (c >= 3 && c <= 7) chk("bp_rdy_low", 1, o_rdy[1], 1'b0);
      if (c == 9) begin
        chk("bp_idle_rdy", 1, o_rdy[1], 1'b1);
        chk("bp_idle_val", 1, o_val[1], 1'b0);
      end
      tick();
    end

    // Back-to-back on latency=1: accepts in cycles 0, 3, 6.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      settle(1'b1, 1'b1, 1'b1, 3'd0);
      chk("b2b_rqe", 1, o_rqe[1], (c % 3) == 0);
      chk("b2b_val", 1, o_val[1], c == 3 || c == 6);
      tick();
    end

    // Reset during WAIT on latency=5.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      settle(1'b1, c == 0, 1'b1, 3'd1);
      tick();
    end
    settle(1'b0, 1'b0, 1'b1, 3'd1);
    chk("rstw_rdy", 3, o_rdy[3], 1'b1);
    chk("rstw_val", 3, o_val[3], 1'b0);
    chk("rstw_rse", 3, o_rse[3], 1'b0);
    chk("rstw_wen", 3, o_wen[3], 1'b0);
    tick();
    for (int c = 0; c < 10; c++) begin
      settle(1'b1, 1'b0, 1'b1, 3'd1);
      chk("rstw_after_rdy", 3, o_rdy[3], 1'b1);
      chk("rstw_after_val", 3, o_val[3], 1'b0);
      tick();
    end

    // Unsupported type 2 behaves as a read on latency=2.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      settle(1'b1, c == 0, 1'b1, 3'd2);
      chk("t2_wen", 2, o_wen[2], 1'b0);
      chk("t2_val", 2, o_val[2], c == 4);
      tick();
    end

    // Random traffic with occasional resets, checked by the model on every variant.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      settle(($urandom_range(63) != 0), ($urandom_range(2) != 0), ($urandom_range(3) != 0),
             3'($urandom_range(3)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
